// File: rtl/logic_axi4_stream_arbiter.sv
// Packet-level round-robin arbiter: N AXI4-Stream requesters share one tx stream, grant held until tlast.
// Latency: one cycle to arbitrate; once locked, payload/valid/ready forward combinationally (zero cycles).
// Backpressure: tx_tready goes straight to the owning rx_tready; non-owners and idle state see tready=0.
module logic_axi4_stream_arbiter #(
  parameter int INPUTS      = 2,
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int USE_TKEEP   = 1,
  parameter int USE_TSTRB   = 1,
  parameter int USE_TLAST   = 1,
  localparam int GW  = $clog2(INPUTS),
  localparam int DW  = TDATA_BYTES * 8,
  localparam int KW  = TDATA_BYTES,
  localparam int DEW = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1,
  localparam int UW  = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1,
  localparam int IW  = (TID_WIDTH > 0) ? TID_WIDTH : 1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [INPUTS-1:0]             rx_tvalid,
  output logic [INPUTS-1:0]             rx_tready,
  input  logic [INPUTS-1:0][DW-1:0]     rx_tdata,
  input  logic [INPUTS-1:0][KW-1:0]     rx_tkeep,
  input  logic [INPUTS-1:0][KW-1:0]     rx_tstrb,
  input  logic [INPUTS-1:0]             rx_tlast,
  input  logic [INPUTS-1:0][DEW-1:0]    rx_tdest,
  input  logic [INPUTS-1:0][UW-1:0]     rx_tuser,
  input  logic [INPUTS-1:0][IW-1:0]     rx_tid,
  output logic                          tx_tvalid,
  input  logic                          tx_tready,
  output logic [DW-1:0]                 tx_tdata,
  output logic [KW-1:0]                 tx_tkeep,
  output logic [KW-1:0]                 tx_tstrb,
  output logic                          tx_tlast,
  output logic [DEW-1:0]                tx_tdest,
  output logic [UW-1:0]                 tx_tuser,
  output logic [IW-1:0]                 tx_tid,
  output logic [GW-1:0]                 grant,
  output logic                          busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] ptr, ptr_nxt, grant_nxt;
  logic [GW-1:0] pick, cand;
  logic          found;
  logic          pkt_end;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      ptr   <= '0;
      grant <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      grant <= grant_nxt;
    end
  end

  // Rotating priority search: first valid requester at or above ptr, wrapping.
  always_comb begin
    pick  = ptr;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < INPUTS; k++) begin
      cand = GW'((int'(ptr) + k) % INPUTS);
      if (!found && rx_tvalid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Payload always follows the registered owner; only valid/ready are gated by state.
  always_comb begin
    tx_tdata = rx_tdata[grant];
    tx_tkeep = (USE_TKEEP > 0) ? rx_tkeep[grant] : '1;
    tx_tstrb = (USE_TSTRB > 0) ? rx_tstrb[grant] : '1;
    tx_tlast = (USE_TLAST > 0) ? rx_tlast[grant] : 1'b1;
    tx_tdest = (TDEST_WIDTH > 0) ? rx_tdest[grant] : '0;
    tx_tuser = (TUSER_WIDTH > 0) ? rx_tuser[grant] : '0;
    tx_tid   = (TID_WIDTH > 0) ? rx_tid[grant] : '0;
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    tx_tvalid = 1'b0;
    rx_tready = '0;
    pkt_end   = 1'b0;
    busy      = (state == LOCKED);
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        tx_tvalid        = rx_tvalid[grant];
        rx_tready[grant] = tx_tready;
        pkt_end          = tx_tvalid && tx_tready && tx_tlast;
        if (pkt_end) begin
          state_nxt = IDLE;
          ptr_nxt   = (grant == GW'(INPUTS - 1)) ? '0 : grant + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_logic_axi4_stream_arbiter.sv
// Directed bench: 4-input arbiter driven from a cycle table plus sequences for fairness and mid-packet reset,
// and a 2-input arbiter without tlast for per-beat alternation.
module tb_logic_axi4_stream_arbiter;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  // 4-input instance
  logic [3:0]       a_rx_tvalid, a_rx_tready, a_rx_tlast;
  logic [3:0][7:0]  a_rx_tdata;
  logic [3:0][0:0]  a_rx_tkeep, a_rx_tstrb, a_rx_tdest, a_rx_tuser, a_rx_tid;
  logic             a_tx_tvalid, a_tx_tready, a_tx_tlast, a_busy;
  logic [7:0]       a_tx_tdata;
  logic [0:0]       a_tx_tkeep, a_tx_tstrb, a_tx_tdest, a_tx_tuser, a_tx_tid;
  logic [1:0]       a_grant;

  // 2-input instance, tlast ignored
  logic [1:0]       b_rx_tvalid, b_rx_tready, b_rx_tlast;
  logic [1:0][7:0]  b_rx_tdata;
  logic [1:0][0:0]  b_rx_tkeep, b_rx_tstrb, b_rx_tdest, b_rx_tuser, b_rx_tid;
  logic             b_tx_tvalid, b_tx_tready, b_tx_tlast, b_busy;
  logic [7:0]       b_tx_tdata;
  logic [0:0]       b_tx_tkeep, b_tx_tstrb, b_tx_tdest, b_tx_tuser, b_tx_tid;
  logic [0:0]       b_grant;

  logic_axi4_stream_arbiter #(.INPUTS(4)) u_dut_a (
    .aclk(aclk), .areset(areset),
    .rx_tvalid(a_rx_tvalid), .rx_tready(a_rx_tready), .rx_tdata(a_rx_tdata),
    .rx_tkeep(a_rx_tkeep), .rx_tstrb(a_rx_tstrb), .rx_tlast(a_rx_tlast),
    .rx_tdest(a_rx_tdest), .rx_tuser(a_rx_tuser), .rx_tid(a_rx_tid),
    .tx_tvalid(a_tx_tvalid), .tx_tready(a_tx_tready), .tx_tdata(a_tx_tdata),
    .tx_tkeep(a_tx_tkeep), .tx_tstrb(a_tx_tstrb), .tx_tlast(a_tx_tlast),
    .tx_tdest(a_tx_tdest), .tx_tuser(a_tx_tuser), .tx_tid(a_tx_tid),
    .grant(a_grant), .busy(a_busy)
  );

  logic_axi4_stream_arbiter #(.INPUTS(2), .USE_TLAST(0)) u_dut_b (
    .aclk(aclk), .areset(areset),
    .rx_tvalid(b_rx_tvalid), .rx_tready(b_rx_tready), .rx_tdata(b_rx_tdata),
    .rx_tkeep(b_rx_tkeep), .rx_tstrb(b_rx_tstrb), .rx_tlast(b_rx_tlast),
    .rx_tdest(b_rx_tdest), .rx_tuser(b_rx_tuser), .rx_tid(b_rx_tid),
    .tx_tvalid(b_tx_tvalid), .tx_tready(b_tx_tready), .tx_tdata(b_tx_tdata),
    .tx_tkeep(b_tx_tkeep), .tx_tstrb(b_tx_tstrb), .tx_tlast(b_tx_tlast),
    .tx_tdest(b_tx_tdest), .tx_tuser(b_tx_tuser), .tx_tid(b_tx_tid),
    .grant(b_grant), .busy(b_busy)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  last;
    logic [31:0] dat;
    logic        rdy;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic [3:0]  e_rtr;
    logic [1:0]  e_gnt;
    logic        e_busy;
    logic        e_tl;
  } vec_t;

  vec_t tbl [16];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] last, input logic [31:0] dat,
                              input logic rdy, input logic e_txv, input logic [7:0] e_txd,
                              input logic [3:0] e_rtr, input logic [1:0] e_gnt, input logic e_busy,
                              input logic e_tl);
    vec_t v;
    v.vld = vld; v.last = last; v.dat = dat; v.rdy = rdy;
    v.e_txv = e_txv; v.e_txd = e_txd; v.e_rtr = e_rtr; v.e_gnt = e_gnt;
    v.e_busy = e_busy; v.e_tl = e_tl;
    return v;
  endfunction

  task automatic drive_a(input logic [3:0] vld, input logic [3:0] last, input logic [31:0] dat,
                         input logic rdy);
    a_rx_tvalid = vld;
    a_rx_tlast  = last;
    a_rx_tdata  = dat;
    a_tx_tready = rdy;
  endtask

  int seq [4];
  int pkt;
  int order [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    // all-request reset priority, then single packets, then rx[1] stalled while rx[0] waits
    tbl[0]  = mk(4'h0, 4'h0, 32'h0,        1, 0, 8'h00, 4'h0, 2'd0, 0, 0);
    tbl[1]  = mk(4'hF, 4'hF, 32'h44332211, 1, 0, 8'h00, 4'h0, 2'd0, 0, 0);
    tbl[2]  = mk(4'hF, 4'hF, 32'h44332211, 1, 1, 8'h11, 4'h1, 2'd0, 1, 1);
    tbl[3]  = mk(4'h0, 4'h0, 32'h0,        1, 0, 8'h00, 4'h0, 2'd0, 0, 0);
    tbl[4]  = mk(4'h4, 4'h0, 32'h00A10000, 1, 0, 8'h00, 4'h0, 2'd0, 0, 0);
    tbl[5]  = mk(4'h4, 4'h0, 32'h00A10000, 1, 1, 8'hA1, 4'h4, 2'd2, 1, 0);
    tbl[6]  = mk(4'h4, 4'h0, 32'h00A20000, 1, 1, 8'hA2, 4'h4, 2'd2, 1, 0);
    tbl[7]  = mk(4'h4, 4'h4, 32'h00A30000, 1, 1, 8'hA3, 4'h4, 2'd2, 1, 1);
    tbl[8]  = mk(4'h0, 4'h0, 32'h0,        1, 0, 8'h00, 4'h0, 2'd2, 0, 0);
    tbl[9]  = mk(4'h2, 4'h0, 32'h0000B100, 1, 0, 8'h00, 4'h0, 2'd2, 0, 0);
    tbl[10] = mk(4'h3, 4'h0, 32'h0000B1C0, 1, 1, 8'hB1, 4'h2, 2'd1, 1, 0);
    tbl[11] = mk(4'h3, 4'h0, 32'h0000B2C0, 0, 1, 8'hB2, 4'h0, 2'd1, 1, 0);
    tbl[12] = mk(4'h3, 4'h0, 32'h0000B2C0, 0, 1, 8'hB2, 4'h0, 2'd1, 1, 0);
    tbl[13] = mk(4'h3, 4'h2, 32'h0000B2C0, 1, 1, 8'hB2, 4'h2, 2'd1, 1, 1);
    tbl[14] = mk(4'h1, 4'h1, 32'h000000C0, 1, 0, 8'h00, 4'h0, 2'd1, 0, 0);
    tbl[15] = mk(4'h1, 4'h1, 32'h000000C0, 1, 1, 8'hC0, 4'h1, 2'd0, 1, 1);

    a_rx_tkeep = '1; a_rx_tstrb = '1; a_rx_tdest = '0; a_rx_tuser = '0; a_rx_tid = '0;
    b_rx_tkeep = '1; b_rx_tstrb = '1; b_rx_tdest = '0; b_rx_tuser = '0; b_rx_tid = '0;
    b_rx_tvalid = '0; b_rx_tlast = '0; b_rx_tdata = 16'h6150; b_tx_tready = 1'b1;
    drive_a(4'h0, 4'h0, 32'h0, 1'b1);
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_grant", 32'(a_grant), 32'd0);
    chk("reset_txv", 32'(a_tx_tvalid), 32'd0);
    chk("reset_rtr", 32'(a_rx_tready), 32'd0);
    areset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive_a(tbl[i].vld, tbl[i].last, tbl[i].dat, tbl[i].rdy);
      @(negedge aclk);
      chk($sformatf("v%0d_txv", i), 32'(a_tx_tvalid), 32'(tbl[i].e_txv));
      chk($sformatf("v%0d_rtr", i), 32'(a_rx_tready), 32'(tbl[i].e_rtr));
      chk($sformatf("v%0d_gnt", i), 32'(a_grant), 32'(tbl[i].e_gnt));
      chk($sformatf("v%0d_busy", i), 32'(a_busy), 32'(tbl[i].e_busy));
      if (tbl[i].e_txv) begin
        chk($sformatf("v%0d_txd", i), 32'(a_tx_tdata), 32'(tbl[i].e_txd));
        chk($sformatf("v%0d_tlast", i), 32'(a_tx_tlast), 32'(tbl[i].e_tl));
        chk($sformatf("v%0d_tkeep", i), 32'(a_tx_tkeep), 32'd1);
      end
      @(posedge aclk);
      #1;
    end

    // Round-robin fairness: 0,1,3 always offer 2-beat packets
    areset = 1'b1;
    drive_a(4'h0, 4'h0, 32'h0, 1'b1);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    for (int i = 0; i < 4; i++) seq[i] = 0;
    pkt = 0;
    for (int cyc = 0; cyc < 30 && pkt < 6; cyc++) begin
      logic [3:0]  lst;
      logic [31:0] dat;
      for (int i = 0; i < 4; i++) begin
        lst[i] = seq[i][0];
        dat[i*8 +: 8] = {4'(i), 4'(seq[i])};
      end
      drive_a(4'b1011, lst, dat, 1'b1);
      @(negedge aclk);
      if (a_tx_tvalid && a_tx_tready) begin
        int g;
        g = order[pkt];
        chk($sformatf("rr%0d_gnt", pkt), 32'(a_grant), 32'(g));
        chk($sformatf("rr%0d_txd", pkt), 32'(a_tx_tdata), 32'({4'(g), 4'(seq[g])}));
        if (seq[g][0]) pkt++;
        seq[g]++;
      end
      @(posedge aclk);
      #1;
    end
    chk("rr_packets", 32'(pkt), 32'd6);
    chk("rr_beats0", 32'(seq[0]), 32'd4);
    chk("rr_beats1", 32'(seq[1]), 32'd4);
    chk("rr_beats2", 32'(seq[2]), 32'd0);
    chk("rr_beats3", 32'(seq[3]), 32'd4);

    // Reset on beat 2 of a packet from rx[1], then rx[3] alone wins from ptr 0
    drive_a(4'h2, 4'h0, 32'h0000D100, 1'b1);
    @(posedge aclk);
    #1;
    chk("mr_lock_gnt", 32'(a_grant), 32'd1);
    chk("mr_lock_txd", 32'(a_tx_tdata), 32'hD1);
    @(posedge aclk);
    #1;
    drive_a(4'h2, 4'h0, 32'h0000D200, 1'b1);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    chk("mr_txv", 32'(a_tx_tvalid), 32'd0);
    chk("mr_busy", 32'(a_busy), 32'd0);
    chk("mr_gnt", 32'(a_grant), 32'd0);
    areset = 1'b0;
    drive_a(4'h8, 4'h8, 32'hE3000000, 1'b1);
    @(posedge aclk);
    #1;
    chk("mr_after_gnt", 32'(a_grant), 32'd3);
    chk("mr_after_busy", 32'(a_busy), 32'd1);
    chk("mr_after_txd", 32'(a_tx_tdata), 32'hE3);
    drive_a(4'h0, 4'h0, 32'h0, 1'b1);

    // No tlast: both inputs stream, grant alternates per beat with a bubble between
    b_rx_tvalid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
      chk($sformatf("nl%0d_busy", k), 32'(b_busy), 32'(k % 2));
      chk($sformatf("nl%0d_txv", k), 32'(b_tx_tvalid), 32'(k % 2));
      if (k % 2 == 1) begin
        chk($sformatf("nl%0d_gnt", k), 32'(b_grant), 32'(((k - 1) / 2) % 2));
        chk($sformatf("nl%0d_tlast", k), 32'(b_tx_tlast), 32'd1);
        chk($sformatf("nl%0d_txd", k), 32'(b_tx_tdata), (((k - 1) / 2) % 2 == 1) ? 32'h61 : 32'h50);
      end
      @(posedge aclk);
      #1;
    end
    b_rx_tvalid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
